// File: rtl/chess_move_select_ctrl.sv
// Two-click move-selection controller: click -> tile conversion, occupancy query, move handshake.
// Optional auto-deselect of a held source tile is enabled by defining CHESS_SEL_TIMEOUT_EN.
module chess_move_select_ctrl #(
  parameter int BOARD_X0 = 140,
  parameter int BOARD_Y0 = 60,
  parameter int TILE     = 45
`ifdef CHESS_SEL_TIMEOUT_EN
  , parameter int SEL_TIMEOUT = 600
`endif
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       click,
  input  logic [9:0] click_x,
  input  logic [9:0] click_y,
  output logic       occ_req,
  output logic [2:0] occ_row,
  output logic [2:0] occ_col,
  input  logic       occ_rsp_valid,
  input  logic       occ_rsp_empty,
  input  logic       occ_rsp_color,
  output logic       move_valid,
  input  logic       move_ready,
  output logic [2:0] src_row,
  output logic [2:0] src_col,
  output logic [2:0] dst_row,
  output logic [2:0] dst_col,
  output logic       turn,
  output logic       sel_active,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, CONV_SRC, QRY_SRC, WAIT_SRC, SRC_SEL,
    CONV_DST, QRY_DST, WAIT_DST, ISSUE
  } state_t;

  localparam logic [9:0] X_MIN  = 10'(BOARD_X0);
  localparam logic [9:0] X_MAX  = 10'(BOARD_X0 + 8 * TILE - 1);
  localparam logic [9:0] Y_MIN  = 10'(BOARD_Y0);
  localparam logic [9:0] Y_MAX  = 10'(BOARD_Y0 + 8 * TILE - 1);
  localparam logic [9:0] TILE_W = 10'(TILE);

  state_t     state_reg, state_next;
  logic [9:0] rem_x_reg, rem_y_reg;
  logic [2:0] col_reg, row_reg;
  logic [2:0] src_row_reg, src_col_reg, dst_row_reg, dst_col_reg;
  logic       turn_reg;
  logic       on_board, conv_done, conv_load, src_load, dst_load, turn_flip;
  logic       sel_timeout;

  assign on_board  = (click_x >= X_MIN) && (click_x <= X_MAX) &&
                     (click_y >= Y_MIN) && (click_y <= Y_MAX);
  assign conv_done = (rem_x_reg < TILE_W) && (rem_y_reg < TILE_W);

  // Repeated-subtraction divider; x and y step together, so latency is max(col,row)+1.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rem_x_reg <= '0;
      rem_y_reg <= '0;
      col_reg   <= '0;
      row_reg   <= '0;
    end else if (conv_load) begin
      rem_x_reg <= click_x - X_MIN;
      rem_y_reg <= click_y - Y_MIN;
      col_reg   <= '0;
      row_reg   <= '0;
    end else if (state_reg == CONV_SRC || state_reg == CONV_DST) begin
      if (rem_x_reg >= TILE_W) begin
        rem_x_reg <= rem_x_reg - TILE_W;
        col_reg   <= col_reg + 3'd1;
      end
      if (rem_y_reg >= TILE_W) begin
        rem_y_reg <= rem_y_reg - TILE_W;
        row_reg   <= row_reg + 3'd1;
      end
    end
  end

`ifdef CHESS_SEL_TIMEOUT_EN
  logic [15:0] tmo_cnt_reg;

  // Cleared on every entry into SRC_SEL, including a reselect from WAIT_DST.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      tmo_cnt_reg <= '0;
    else if (state_next == SRC_SEL && state_reg != SRC_SEL)
      tmo_cnt_reg <= '0;
    else if (state_reg == SRC_SEL)
      tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
  end

  assign sel_timeout = (state_reg == SRC_SEL) && (tmo_cnt_reg == 16'(SEL_TIMEOUT - 1));
`else
  assign sel_timeout = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg   <= IDLE;
      src_row_reg <= '0;
      src_col_reg <= '0;
      dst_row_reg <= '0;
      dst_col_reg <= '0;
      turn_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (src_load) begin
        src_row_reg <= row_reg;
        src_col_reg <= col_reg;
      end
      if (dst_load) begin
        dst_row_reg <= row_reg;
        dst_col_reg <= col_reg;
      end
      if (turn_flip)
        turn_reg <= ~turn_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    conv_load  = 1'b0;
    src_load   = 1'b0;
    dst_load   = 1'b0;
    turn_flip  = 1'b0;
    case (state_reg)
      IDLE: if (click && on_board) begin
        conv_load  = 1'b1;
        state_next = CONV_SRC;
      end
      CONV_SRC: if (conv_done) state_next = QRY_SRC;
      QRY_SRC:  state_next = WAIT_SRC;
      WAIT_SRC: if (occ_rsp_valid) begin
        if (!occ_rsp_empty && occ_rsp_color == turn_reg) begin
          src_load   = 1'b1;
          state_next = SRC_SEL;
        end else begin
          state_next = IDLE;
        end
      end
      SRC_SEL: begin
        if (sel_timeout) begin
          state_next = IDLE;
        end else if (click) begin
          if (on_board) begin
            conv_load  = 1'b1;
            state_next = CONV_DST;
          end else begin
            state_next = IDLE;
          end
        end
      end
      CONV_DST: if (conv_done) begin
        if (row_reg == src_row_reg && col_reg == src_col_reg) state_next = IDLE;
        else state_next = QRY_DST;
      end
      QRY_DST:  state_next = WAIT_DST;
      WAIT_DST: if (occ_rsp_valid) begin
        if (occ_rsp_empty || occ_rsp_color != turn_reg) begin
          dst_load   = 1'b1;
          state_next = ISSUE;
        end else begin
          src_load   = 1'b1;
          state_next = SRC_SEL;
        end
      end
      ISSUE: if (move_ready) begin
        turn_flip  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign occ_req    = (state_reg == QRY_SRC) || (state_reg == QRY_DST);
  assign occ_row    = row_reg;
  assign occ_col    = col_reg;
  assign move_valid = (state_reg == ISSUE);
  assign src_row    = src_row_reg;
  assign src_col    = src_col_reg;
  assign dst_row    = dst_row_reg;
  assign dst_col    = dst_col_reg;
  assign turn       = turn_reg;
  assign sel_active = (state_reg == SRC_SEL) || (state_reg == CONV_DST) ||
                      (state_reg == QRY_DST) || (state_reg == WAIT_DST) ||
                      (state_reg == ISSUE);
  assign busy       = (state_reg != IDLE) && (state_reg != SRC_SEL);

endmodule
